// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: round-robin or fixed-priority grant, one transaction
// at a time through IDLE -> ISSUE -> WAIT -> RESP, with a busy timeout in WAIT.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_ld,
  input  logic              p0_wr,
  input  logic [2:0]        p0_mt,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_done,
  output logic              p0_err,
  output logic              p0_grant,
  input  logic              p1_ld,
  input  logic              p1_wr,
  input  logic [2:0]        p1_mt,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_done,
  output logic              p1_err,
  output logic              p1_grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ld,
  output logic              mem_wr,
  output logic [2:0]        mem_mt,
  output logic [DATA_W-1:0] mem_data_input,
  input  logic [DATA_W-1:0] mem_data_output,
  input  logic              mem_busy,
  output logic              timeout_flag
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic                op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          mt_q, mt_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                err_pend_q, err_pend_d;
  logic                tflag_q, tflag_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                req0, req1, pick;

  assign req0 = p0_ld | p0_wr;
  assign req1 = p1_ld | p1_wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_wr_q      <= 1'b0;
      addr_q       <= '0;
      mt_q         <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      err_pend_q   <= 1'b0;
      tflag_q      <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      op_wr_q      <= op_wr_d;
      addr_q       <= addr_d;
      mt_q         <= mt_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      err_pend_q   <= err_pend_d;
      tflag_q      <= tflag_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    op_wr_d      = op_wr_q;
    addr_d       = addr_q;
    mt_d         = mt_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    err_pend_d   = err_pend_q;
    tflag_d      = tflag_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    cnt_inc      = cnt_q + CNT_W'(1);

    // On a tie, round-robin hands the grant to the port that did not have it last.
    if (req0 && req1) begin
      pick = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
    end else begin
      pick = req1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d      = pick;
          last_grant_d = pick;
          op_wr_d      = pick ? p1_wr    : p0_wr;
          addr_d       = pick ? p1_addr  : p0_addr;
          mt_d         = pick ? p1_mt    : p0_mt;
          wdata_d      = pick ? p1_wdata : p0_wdata;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!mem_busy) begin
          if (!op_wr_q) begin
            if (owner_q) rdata1_d = mem_data_output;
            else         rdata0_d = mem_data_output;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc;
          // Abort on the TIMEOUT-th busy cycle, counting the current one.
          if ((TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT))) begin
            err_pend_d = 1'b1;
            tflag_d    = 1'b1;
            state_d    = S_RESP;
          end
        end
      end
      S_RESP: begin
        cnt_d      = '0;
        err_pend_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign p0_grant       = (state_q != S_IDLE) && !owner_q;
  assign p1_grant       = (state_q != S_IDLE) &&  owner_q;
  assign p0_done        = (state_q == S_RESP) && !owner_q;
  assign p1_done        = (state_q == S_RESP) &&  owner_q;
  assign p0_err         = p0_done && err_pend_q;
  assign p1_err         = p1_done && err_pend_q;
  assign p0_rdata       = rdata0_q;
  assign p1_rdata       = rdata1_q;
  assign mem_ld         = (state_q == S_ISSUE) && !op_wr_q;
  assign mem_wr         = (state_q == S_ISSUE) &&  op_wr_q;
  assign mem_addr       = addr_q;
  assign mem_mt         = mt_q;
  assign mem_data_input = wdata_q;
  assign timeout_flag   = tflag_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a round-robin instance with TIMEOUT=8 and a
// fixed-priority instance, driven against a behavioural memory responder.
module tb_mem_arbiter;

  localparam int unsigned TO = 8;
  localparam logic [31:0] XK = 32'hA5A5_0000;

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic        clk, rst;
  logic        p0_ld, p0_wr, p1_ld, p1_wr;
  logic [2:0]  p0_mt, p1_mt, mem_mt;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_done, p1_done, p0_err, p1_err, p0_grant, p1_grant;
  logic [31:0] mem_addr, mem_data_input, mem_data_output;
  logic        mem_ld, mem_wr, mem_busy, timeout_flag;

  logic        b_p0_ld, b_p1_ld;
  logic [31:0] b_p0_rdata, b_p1_rdata, b_mem_addr, b_mem_din;
  logic        b_p0_done, b_p1_done, b_p0_err, b_p1_err, b_p0_grant, b_p1_grant;
  logic        b_mem_ld, b_mem_wr, b_tflag;
  logic [2:0]  b_mem_mt;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_ld     = 0;
  int          n_wr     = 0;
  int          mem_len  = 0;
  int          rem      = 0;
  bit          mem_stuck = 1'b0;
  bit          use_val   = 1'b0;
  logic [31:0] mem_val   = '0;
  logic [31:0] exp_rd [2];
  exp_t        sb [$];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset(rst),
    .p0_ld(p0_ld), .p0_wr(p0_wr), .p0_mt(p0_mt), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_done(p0_done), .p0_err(p0_err), .p0_grant(p0_grant),
    .p1_ld(p1_ld), .p1_wr(p1_wr), .p1_mt(p1_mt), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_done(p1_done), .p1_err(p1_err), .p1_grant(p1_grant),
    .mem_addr(mem_addr), .mem_ld(mem_ld), .mem_wr(mem_wr), .mem_mt(mem_mt),
    .mem_data_input(mem_data_input), .mem_data_output(mem_data_output),
    .mem_busy(mem_busy), .timeout_flag(timeout_flag)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255), .FIXED_PRIO(1)) dut_b (
    .clk(clk), .reset(rst),
    .p0_ld(b_p0_ld), .p0_wr(1'b0), .p0_mt(3'd0), .p0_addr(32'h0000_0010), .p0_wdata(32'h0),
    .p0_rdata(b_p0_rdata), .p0_done(b_p0_done), .p0_err(b_p0_err), .p0_grant(b_p0_grant),
    .p1_ld(b_p1_ld), .p1_wr(1'b0), .p1_mt(3'd0), .p1_addr(32'h0000_0020), .p1_wdata(32'h0),
    .p1_rdata(b_p1_rdata), .p1_done(b_p1_done), .p1_err(b_p1_err), .p1_grant(b_p1_grant),
    .mem_addr(b_mem_addr), .mem_ld(b_mem_ld), .mem_wr(b_mem_wr), .mem_mt(b_mem_mt),
    .mem_data_input(b_mem_din), .mem_data_output(32'h1234_0000),
    .mem_busy(1'b0), .timeout_flag(b_tflag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory responder: busy for mem_len cycles after a strobe (or forever when stuck).
  initial forever begin
    @(negedge clk);
    if (rst) begin
      rem      = 0;
      mem_busy = 1'b0;
    end else if (mem_ld || mem_wr) begin
      n_ld    += int'(mem_ld);
      n_wr    += int'(mem_wr);
      rem      = mem_len;
      mem_busy = mem_stuck;
      mem_data_output = use_val ? mem_val : (mem_addr ^ XK);
    end else if (mem_stuck) begin
      mem_busy = 1'b1;
    end else if (rem > 0) begin
      mem_busy = 1'b1;
      rem--;
    end else begin
      mem_busy = 1'b0;
    end
  end

  // Scoreboard consumer.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (mem_ld && mem_wr) check("strobe_exclusive", 1, 0);
      if ((p0_err && !p0_done) || (p1_err && !p1_done)) check("err_without_done", 1, 0);
      if (p0_done || p1_done) begin
        if (sb.size() == 0) begin
          check("done_unexpected", {p1_done, p0_done}, 0);
        end else begin
          e = sb.pop_front();
          check("done_port", {p1_done, p0_done}, (e.port != 0) ? 2'b10 : 2'b01);
          check("done_cycle", cyc, e.cyc);
          check("done_err", (e.port != 0) ? p1_err : p0_err, e.err);
          check("rdata", (e.port != 0) ? p1_rdata : p0_rdata, e.rdata);
        end
      end
    end
  end

  task automatic set_req(input int port, input logic ld, input logic wr, input logic [31:0] a,
                         input logic [2:0] m, input logic [31:0] d);
    if (port == 0) begin
      p0_ld = ld; p0_wr = wr; p0_addr = a; p0_mt = m; p0_wdata = d;
    end else begin
      p1_ld = ld; p1_wr = wr; p1_addr = a; p1_mt = m; p1_wdata = d;
    end
  endtask

  task automatic run_txn(input int port, input logic ld, input logic wr, input logic [31:0] addr,
                         input logic [2:0] mt, input logic [31:0] wdata, input int busy,
                         input bit stuck, input bit mut);
    exp_t e;
    int   t0, ld0, wr0;
    bit   seen;
    logic rd;
    @(negedge clk);
    rd        = ld & ~wr;
    mem_len   = busy;
    mem_stuck = stuck;
    if (rd && !stuck) exp_rd[port] = use_val ? mem_val : (addr ^ XK);
    t0  = cyc;
    ld0 = n_ld;
    wr0 = n_wr;
    e.port  = port;
    e.err   = stuck;
    e.rdata = exp_rd[port];
    e.cyc   = stuck ? (t0 + 2 + int'(TO)) : (t0 + 3 + busy);
    sb.push_back(e);
    set_req(port, ld, wr, addr, mt, wdata);
    @(negedge clk);
    check("issue_ld", mem_ld, rd);
    check("issue_wr", mem_wr, wr);
    check("issue_addr", mem_addr, addr);
    check("issue_mt", mem_mt, mt);
    check("issue_wdata", mem_data_input, wdata);
    check("grant_owner", (port != 0) ? p1_grant : p0_grant, 1);
    check("grant_other", (port != 0) ? p0_grant : p1_grant, 0);
    if (mut) set_req(port, ld, wr, addr + 32'h40, mt ^ 3'b111, ~wdata);
    @(negedge clk);
    if (mut) begin
      check("wait_addr_held", mem_addr, addr);
      check("wait_wdata_held", mem_data_input, wdata);
      check("wait_mt_held", mem_mt, mt);
      check("wait_strobes_low", {mem_ld, mem_wr}, 0);
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if ((port != 0) ? p1_done : p0_done) seen = 1'b1;
      else @(negedge clk);
    end
    check("done_seen", seen, 1);
    set_req(port, 1'b0, 1'b0, addr, mt, wdata);
    check("ld_pulses", n_ld - ld0, rd);
    check("wr_pulses", n_wr - wr0, wr);
    mem_stuck = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    int t0, p1_seen, p0_dones, ld0;
    rst = 1'b1;
    p0_ld = 0; p0_wr = 0; p0_mt = '0; p0_addr = '0; p0_wdata = '0;
    p1_ld = 0; p1_wr = 0; p1_mt = '0; p1_addr = '0; p1_wdata = '0;
    b_p0_ld = 0; b_p1_ld = 0;
    mem_busy = 1'b0; mem_data_output = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    repeat (3) @(negedge clk);

    check("rst_strobes", {mem_ld, mem_wr}, 0);
    check("rst_grants", {p0_grant, p1_grant}, 0);
    check("rst_done_err", {p0_done, p1_done, p0_err, p1_err}, 0);
    check("rst_timeout_flag", timeout_flag, 0);
    check("rst_mem_bus", |{mem_addr, mem_mt, mem_data_input}, 0);
    check("rst_rdata", |{p0_rdata, p1_rdata}, 0);
    check("rst_b_outputs", |{b_p0_rdata, b_p1_rdata, b_p0_done, b_p1_done, b_p0_err, b_p1_err,
                             b_p0_grant, b_p1_grant, b_mem_addr, b_mem_din, b_mem_ld, b_mem_wr,
                             b_mem_mt, b_tflag}, 0);
    rst = 1'b0;

    // Fixed priority: p0 hogs the port for three transactions, then p1 gets in.
    @(negedge clk);
    t0 = cyc;
    b_p0_ld = 1'b1;
    b_p1_ld = 1'b1;
    p1_seen = 0;
    p0_dones = 0;
    while (cyc < t0 + 11) begin
      @(negedge clk);
      if (b_p1_grant) p1_seen++;
      if (b_p0_done) p0_dones++;
    end
    b_p0_ld = 1'b0;
    check("fp_p1_starved", p1_seen, 0);
    check("fp_p0_dones", p0_dones, 3);
    repeat (2) @(negedge clk);
    check("fp_p1_grant", {b_p1_grant, b_p0_grant}, 2'b10);
    repeat (2) @(negedge clk);
    check("fp_p1_done", b_p1_done, 1);
    check("fp_p1_rdata", b_p1_rdata, 32'h1234_0000);
    b_p1_ld = 1'b0;

    // p0 read, two busy cycles.
    use_val = 1'b1;
    mem_val = 32'hDEAD_BEEF;
    run_txn(0, 1'b1, 1'b0, 32'h0000_0100, 3'b010, 32'h0, 2, 1'b0, 1'b0);
    use_val = 1'b0;

    // ld+wr together is a write; fields changed during WAIT must not leak.
    run_txn(0, 1'b1, 1'b1, 32'h0000_0040, 3'b001, 32'h1234_5678, 3, 1'b0, 1'b1);

    // Round-robin from reset with both ports requesting continuously.
    do_reset();
    t0 = cyc;
    mem_len = 0;
    exp_rd[0] = 32'h0000_0010 ^ XK;
    exp_rd[1] = 32'h0000_0020 ^ XK;
    sb.push_back('{0, 1'b0, exp_rd[0], t0 + 3});
    sb.push_back('{1, 1'b0, exp_rd[1], t0 + 7});
    sb.push_back('{0, 1'b0, exp_rd[0], t0 + 11});
    sb.push_back('{1, 1'b0, exp_rd[1], t0 + 15});
    set_req(0, 1'b1, 1'b0, 32'h0000_0010, 3'b010, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h0000_0020, 3'b010, 32'h0);
    while (cyc < t0 + 15) begin
      @(negedge clk);
      if (cyc == t0 + 1) check("rr_first_grant", {p1_grant, p0_grant}, 2'b01);
      if (cyc == t0 + 5) check("rr_second_grant", {p1_grant, p0_grant}, 2'b10);
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 3'b0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 3'b0, 32'h0);
    repeat (2) @(negedge clk);
    check("rr_drained", sb.size(), 0);

    // p1 write against a hung memory, then a normal p0 read.
    run_txn(1, 1'b0, 1'b1, 32'h0000_0200, 3'b010, 32'hCAFE_F00D, 0, 1'b1, 1'b0);
    check("timeout_flag_set", timeout_flag, 1);
    run_txn(0, 1'b1, 1'b0, 32'h0000_0300, 3'b010, 32'h0, 1, 1'b0, 1'b0);
    check("timeout_flag_sticky", timeout_flag, 1);

    // Reset in the middle of WAIT.
    @(negedge clk);
    mem_len = 6;
    ld0 = n_ld;
    set_req(0, 1'b1, 1'b0, 32'h0000_0500, 3'b010, 32'h0);
    repeat (2) @(negedge clk);
    check("pre_reset_grant", p0_grant, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_grants", {p0_grant, p1_grant}, 0);
    check("async_rst_strobes", {mem_ld, mem_wr}, 0);
    check("async_rst_done", {p0_done, p1_done}, 0);
    check("async_rst_tflag", timeout_flag, 0);
    set_req(0, 1'b0, 1'b0, 32'h0, 3'b0, 32'h0);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("post_rst_no_strobe", n_ld - ld0, 1);
    run_txn(1, 1'b1, 1'b0, 32'h0000_0600, 3'b100, 32'h0, 0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single memory port (address, ld/wr strobes, mt, data in/out, busy) between two requesters.
- Port 0 is the control section's load/store/fetch path. Port 1 is a secondary master (debug/DMA loader).
- Sits between the requesters and the memory block.
- Sequences each transaction: issue strobe, wait on busy, capture read data, acknowledge.
- Adds a busy timeout so a hung memory cannot deadlock the core.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max WAIT cycles with busy high before abort; 0 disables timeout
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins ties

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
p0_ld / p1_ld  in  1  read request (level)
p0_wr / p1_wr  in  1  write request (level)
p0_mt / p1_mt  in  3  memory type (size/sign), passed to memory
p0_addr / p1_addr  in  ADDR_W  request address
p0_wdata / p1_wdata  in  DATA_W  write data
p0_rdata / p1_rdata  out  DATA_W  registered read data
p0_done / p1_done  out  1  one-cycle completion pulse
p0_err / p1_err  out  1  valid with done; 1 = timed out
p0_grant / p1_grant  out  1  port owns memory (ISSUE through RESP)
mem_addr  out  ADDR_W  to memory address
mem_ld  out  1  read strobe
mem_wr  out  1  write strobe
mem_mt  out  3  to memory mt
mem_data_input  out  DATA_W  write data to memory
mem_data_output  in  DATA_W  read data from memory
mem_busy  in  1  memory busy
timeout_flag  out  1  sticky; set on any timeout, cleared only by reset

Behaviour:
- Reset values: all outputs 0. State = IDLE, last_grant = 1 (port 0 wins the first tie), timeout counter = 0.
- Reset takes effect immediately, including mid-transaction: strobes drop at once and no done pulse follows release.
- A request is pN_ld | pN_wr. If both are high, the transaction is a write.
- Requesters hold request fields stable until done. Fields are latched at grant, so later changes never reach the memory side.
- IDLE: if any request is pending, choose the winner and go to ISSUE next cycle.
  - Round-robin: on a tie, grant the port != last_grant.
  - FIXED_PRIO=1: port 0 always wins ties.
  - Latch op, addr, mt and wdata from the winner. Set pN_grant and last_grant.
- ISSUE (exactly 1 cycle):
  - mem_ld or mem_wr = 1 per the latched op.
  - mem_addr, mem_mt and mem_data_input are driven from the latches.
  - Next state: WAIT.
- WAIT:
  - Strobes are 0; mem_addr, mem_mt and mem_data_input stay held.
  - Counter increments each cycle that mem_busy = 1.
  - If mem_busy = 0: the transaction is complete. For a read, capture mem_data_output into the owner's rdata register. Go to RESP.
  - Else if TIMEOUT != 0 and counter == TIMEOUT: abort. Set err_pending and timeout_flag, leave rdata unchanged, go to RESP.
- RESP (1 cycle):
  - Owner's pN_done = 1, and pN_err = err_pending.
  - Clear grant, counter and err_pending. Go to IDLE.
- Minimum latency (busy never high): request seen in cycle 0, mem strobe in cycle 1, done in cycle 3. Each busy-high cycle adds 1.
- pN_rdata holds its value until that port's next successful read completes. Writes and timeouts do not change it.
- Back-to-back requests: a request still asserted in the cycle after pN_done counts as a new transaction. A requester must drop its request on the edge where it samples done if it wants no repeat.
- The non-owner's inputs are ignored until IDLE.
- At most one of mem_ld / mem_wr is ever high, and only in ISSUE.
- Throughput: no idle bubble beyond IDLE, so 4 cycles minimum per transaction.

Test Plan:
- p0 read, addr 0x100, mt 3'b010; memory holds busy 2 cycles then returns 0xDEADBEEF -> mem_ld high in cycle 1 only, mem_addr = 0x100, p0_done in cycle 5, p0_rdata = 0xDEADBEEF, p0_err = 0.
- Both ports request reads continuously from reset, FIXED_PRIO=0, zero-wait memory -> grants go p0, p1, p0, p1; each done 4 cycles apart.
- Same stimulus with FIXED_PRIO=1 -> p1_grant never asserts while p0 requests; p1 is granted in the first IDLE after p0 drops its request.
- TIMEOUT=8, p1 write with mem_busy stuck high -> p1_done with p1_err = 1 at 8 busy cycles after WAIT entry, timeout_flag = 1, p1_rdata unchanged. A subsequent p0 read with normal memory completes normally.
- Reset asserted during WAIT -> mem_ld, mem_wr and all done/grant outputs go 0 asynchronously. After release with no requests: no done pulse, state IDLE.
- p0_ld = p0_wr = 1, wdata 0x12345678, addr 0x40; p0_addr changed to 0x80 during WAIT -> a single mem_wr pulse, mem_addr stays 0x40, mem_data_input = 0x12345678, mem_ld never high.
